// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, read-only instruction cache, 4-byte lines.
//
// Sits between the instruction fetch stage and the byte-wide memory arbiter.
// Lookup is combinational. On a miss, the cache fills one line, one byte per
// mem_ready handshake. Fetch keeps presenting the same PC until
// inst_available rises.
//
// Build option: define ICACHE_RVC_EN to enable compressed (16-bit) support.
// This covers halfword-aligned fetch, the length decode, and the lookup and
// fill of the following line for 32-bit instructions that straddle two lines.
// Without the macro, fetch is word-aligned, inst is the full line word, and
// inst_length is always 1.
//
// Ports:
//   clk_in          clock
//   rst_in          asynchronous reset, active low
//   rdy_in          global ready; low freezes FSM, counter, request and array
//   fetch_addr      fetch PC
//   inst_available  instruction at fetch_addr fully present (combinational)
//   inst            instruction word (16-bit ones zero-extended), 0 if absent
//   inst_length     1 = 32-bit, 0 = 16-bit
//   mem_req         byte read request (registered)
//   mem_addr        byte address of the request (registered)
//   mem_ready       arbiter accepted the request; mem_data valid this cycle
//   mem_data        returned byte
module inst_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] fetch_addr,
    output logic        inst_available,
    output logic [31:0] inst,
    output logic        inst_length,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic {IDLE, FILL} state_t;

    // Line storage. Only the valid bits need a reset.
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    state_t      state;
    logic [1:0]  cnt;
    logic [23:0] fill_buf;   // first three bytes of the line, byte 0 lowest

    logic [31:0]           word_addr;
    logic [INDEX_BITS-1:0] lo_idx;
    logic [TAG_W-1:0]      lo_tag;
    logic                  lo_hit;
    logic [31:0]           lo_word;
    logic                  miss_req;
    logic [31:0]           miss_base;
    logic                  fill_done;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]      fill_tag;

    assign word_addr = fetch_addr & ~32'd3;
    assign lo_idx    = word_addr[INDEX_BITS+1:2];
    assign lo_tag    = word_addr[31:INDEX_BITS+2];
    assign lo_hit    = valid_q[lo_idx] && (tag_q[lo_idx] == lo_tag);
    assign lo_word   = data_q[lo_idx];

`ifdef ICACHE_RVC_EN
    logic [31:0]           hi_base;
    logic [INDEX_BITS-1:0] hi_idx;
    logic [TAG_W-1:0]      hi_tag;
    logic                  hi_hit;
    logic [15:0]           hi_half;
    logic [15:0]           lo_half;
    logic                  is32;
    logic                  straddle;

    // Line holding fetch_addr+2. The add wraps at 2^32, so index rolls to 0
    // and the tag carries.
    assign hi_base  = (fetch_addr + 32'd2) & ~32'd3;
    assign hi_idx   = hi_base[INDEX_BITS+1:2];
    assign hi_tag   = hi_base[31:INDEX_BITS+2];
    assign hi_hit   = valid_q[hi_idx] && (tag_q[hi_idx] == hi_tag);
    assign hi_half  = 16'(data_q[hi_idx]);
    assign lo_half  = 16'(lo_word >> {fetch_addr[1:0], 3'b000});
    assign is32     = (lo_half[1:0] == 2'b11);
    assign straddle = is32 && fetch_addr[1];

    always_comb begin
        inst_available = lo_hit && (!is32 || !fetch_addr[1] || hi_hit);
        inst           = '0;
        inst_length    = 1'b0;
        if (inst_available) begin
            inst_length = is32;
            if (!is32)
                inst = {16'h0000, lo_half};
            else if (straddle)
                inst = {hi_half, lo_half};
            else
                inst = lo_word;
        end
    end

    // The lo line always takes priority; the hi line is fetched on the
    // re-detect cycle after the lo fill lands.
    assign miss_req  = !lo_hit || (straddle && !hi_hit);
    assign miss_base = !lo_hit ? word_addr : hi_base;
`else
    assign inst_available = lo_hit;
    assign inst           = lo_hit ? lo_word : 32'h0;
    assign inst_length    = 1'b1;
    assign miss_req       = !lo_hit;
    assign miss_base      = word_addr;
`endif

    // mem_addr holds the line base plus the byte counter for the whole fill.
    // Its upper bits therefore name the line that is being filled.
    assign fill_idx  = mem_addr[INDEX_BITS+1:2];
    assign fill_tag  = mem_addr[31:INDEX_BITS+2];
    assign fill_done = (state == FILL) && rdy_in && mem_ready && (cnt == 2'd3);

    always_ff @(posedge clk_in) begin
        if (fill_done) begin
            data_q[fill_idx] <= {mem_data, fill_buf};
            tag_q[fill_idx]  <= fill_tag;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q  <= '0;
            state    <= IDLE;
            cnt      <= 2'd0;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
            fill_buf <= 24'h0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        state    <= FILL;
                        mem_req  <= 1'b1;
                        mem_addr <= miss_base;
                        cnt      <= 2'd0;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        if (cnt == 2'd3) begin
                            valid_q[fill_idx] <= 1'b1;
                            state             <= IDLE;
                            mem_req           <= 1'b0;
                            cnt               <= 2'd0;
                        end else begin
                            // Shift in from the top. After three bytes,
                            // byte 0 sits in the low byte.
                            fill_buf <= {mem_data, fill_buf[23:8]};
                            cnt      <= cnt + 2'd1;
                            mem_addr <= {mem_addr[31:2], cnt + 2'd1};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
